// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
// spi_pkg: register map, control/status bit positions and bus FSM states
// shared by the SPI master and slave blocks.
package spi_pkg;

    localparam logic SPI_ADR_DATA = 1'b0;
    localparam logic SPI_ADR_CTRL = 1'b1;

    // conf byte (control word bits [23:16])
    localparam int CONF_CPHA = 0;
    localparam int CONF_CPOL = 1;
    localparam int CONF_RXIE = 2;
    localparam int CONF_TXIE = 3;

    // status bits in the low nibble of the control word
    localparam int ST_RX_UNREAD = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_SS_ACT    = 3;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_DONE = 1'b1
    } bus_state_e;

    function automatic logic [31:0] pack_status(input logic [7:0] conf,
                                                input logic       ss_act,
                                                input logic       overrun,
                                                input logic       tx_full,
                                                input logic       rx_unread);
        logic [31:0] w;
        w               = '0;
        w[23:16]        = conf;
        w[ST_SS_ACT]    = ss_act;
        w[ST_OVERRUN]   = overrun;
        w[ST_TX_FULL]   = tx_full;
        w[ST_RX_UNREAD] = rx_unread;
        return w;
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
`timescale 1ns/1ps
// spi_slave_sync: brings sclk/ss_n/mosi into clk_i with two flops and
// produces single-cycle edge strobes from the synchronised levels.
module spi_slave_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sclk_i,
    input  logic ss_n_i,
    input  logic mosi_i,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic ss_fall_o,
    output logic ss_rise_o,
    output logic ss_act_o,
    output logic mosi_o
);

    // bit 0 sclk, bit 1 ss_n, bit 2 mosi; ss_n resets deselected so that
    // leaving reset never fakes a select edge
    localparam logic [2:0] PIN_RESET = 3'b010;

    logic [2:0] meta_q;
    logic [2:0] sync_q;
    logic [1:0] prev_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= PIN_RESET;
            sync_q <= PIN_RESET;
            prev_q <= PIN_RESET[1:0];
        end else begin
            meta_q <= {mosi_i, ss_n_i, sclk_i};
            sync_q <= meta_q;
            prev_q <= sync_q[1:0];
        end
    end

    assign sclk_rise_o =  sync_q[0] & ~prev_q[0];
    assign sclk_fall_o = ~sync_q[0] &  prev_q[0];
    assign ss_fall_o   = ~sync_q[1] &  prev_q[1];
    assign ss_rise_o   =  sync_q[1] & ~prev_q[1];
    assign ss_act_o    = ~sync_q[1];
    assign mosi_o      =  sync_q[2];

endmodule

// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// spi_slave: Wishbone-attached SPI responder, 8-bit frames MSB first.
// Define SPI_SLAVE_IRQ_EN to build the registered interrupt output.
module spi_slave
    import spi_pkg::*;
#(
    parameter logic [7:0] FILL_BYTE = 8'hFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic        adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    input  logic        sclk,
    input  logic        ss_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic        irq
);

    logic sclk_rise, sclk_fall, ss_fall, ss_rise, ss_act, mosi_s;

    spi_slave_sync u_sync (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .sclk_i      (sclk),
        .ss_n_i      (ss_n),
        .mosi_i      (mosi),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .ss_fall_o   (ss_fall),
        .ss_rise_o   (ss_rise),
        .ss_act_o    (ss_act),
        .mosi_o      (mosi_s)
    );

    bus_state_e  state_q, state_d;
    logic [31:0] dat_q, dat_d;
    logic [7:0]  conf_q, conf_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        tx_full_q, tx_full_d;
    logic        rx_unread_q, rx_unread_d;
    logic        overrun_q, overrun_d;
    logic        miso_q, miso_d;
    logic        cpol_q, cpol_d;
    logic        cpha_q, cpha_d;
    logic        load_pend_q, load_pend_d;

    logic       access, wr_data, rd_data, wr_ctrl, rd_ctrl;
    logic       lead_e, trail_e, sample_e, shift_e, rx_unread_eff;
    logic [7:0] load_byte, rx_next;

    always_comb begin
        // NOTE: every next-state signal takes its held value first, so no path
        // through this block leaves one unassigned (which would infer a latch).
        state_d     = state_q;
        dat_d       = dat_q;
        conf_d      = conf_q;
        tx_byte_d   = tx_byte_q;
        tx_shift_d  = tx_shift_q;
        rx_byte_d   = rx_byte_q;
        rx_shift_d  = rx_shift_q;
        bitcnt_d    = bitcnt_q;
        tx_full_d   = tx_full_q;
        overrun_d   = overrun_q;
        miso_d      = miso_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        load_pend_d = load_pend_q;

        access  = (state_q == BUS_IDLE) & cyc_i & stb_i;
        wr_data = access &  we_i & (adr_i == SPI_ADR_DATA);
        rd_data = access & ~we_i & (adr_i == SPI_ADR_DATA);
        wr_ctrl = access &  we_i & (adr_i == SPI_ADR_CTRL);
        rd_ctrl = access & ~we_i & (adr_i == SPI_ADR_CTRL);

        case (state_q)
            BUS_IDLE: if (cyc_i & stb_i) state_d = BUS_DONE;
            default:  state_d = BUS_IDLE;
        endcase

        if (wr_data) tx_byte_d = dat_i[7:0];
        if (rd_data) dat_d = {24'h000000, rx_byte_q};
        if (rd_ctrl) dat_d = pack_status(conf_q, ss_act, overrun_q, tx_full_q, rx_unread_q);
        if (wr_ctrl) begin
            if (sel_i[2]) conf_d = dat_i[23:16];
            if (sel_i[0] & dat_i[ST_OVERRUN]) overrun_d = 1'b0;
        end

        // a same-cycle data read frees the holding register for a finishing byte
        rx_unread_eff = rx_unread_q & ~rd_data;
        rx_unread_d   = rx_unread_eff;

        lead_e    = cpol_q ? sclk_fall : sclk_rise;
        trail_e   = cpol_q ? sclk_rise : sclk_fall;
        sample_e  = ss_act & (cpha_q ? trail_e : lead_e);
        shift_e   = ss_act & (cpha_q ? lead_e : trail_e);
        load_byte = tx_full_q ? tx_byte_q : FILL_BYTE;
        rx_next   = {rx_shift_q[6:0], mosi_s};

        if (ss_fall) begin
            cpol_d      = conf_q[CONF_CPOL];
            cpha_d      = conf_q[CONF_CPHA];
            bitcnt_d    = 3'd0;
            load_pend_d = 1'b0;
            tx_full_d   = 1'b0;
            if (conf_q[CONF_CPHA]) begin
                tx_shift_d = load_byte;
            end else begin
                miso_d     = load_byte[7];
                tx_shift_d = {load_byte[6:0], 1'b0};
            end
        end else if (ss_rise) begin
            bitcnt_d    = 3'd0;
            load_pend_d = 1'b0;
        end else begin
            if (shift_e) begin
                if (load_pend_q) begin
                    miso_d      = load_byte[7];
                    tx_shift_d  = {load_byte[6:0], 1'b0};
                    tx_full_d   = 1'b0;
                    load_pend_d = 1'b0;
                end else begin
                    miso_d     = tx_shift_q[7];
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end
            if (sample_e) begin
                rx_shift_d = rx_next;
                bitcnt_d   = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    load_pend_d = 1'b1;
                    if (rx_unread_eff) begin
                        overrun_d = 1'b1;
                    end else begin
                        rx_byte_d   = rx_next;
                        rx_unread_d = 1'b1;
                    end
                end
            end
        end

        // a CPU write landing with a load point fills the register for the next byte
        if (wr_data) tx_full_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= BUS_IDLE;
            dat_q       <= '0;
            conf_q      <= '0;
            tx_byte_q   <= '0;
            tx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_shift_q  <= '0;
            bitcnt_q    <= '0;
            tx_full_q   <= 1'b0;
            rx_unread_q <= 1'b0;
            overrun_q   <= 1'b0;
            miso_q      <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            load_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dat_q       <= dat_d;
            conf_q      <= conf_d;
            tx_byte_q   <= tx_byte_d;
            tx_shift_q  <= tx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_shift_q  <= rx_shift_d;
            bitcnt_q    <= bitcnt_d;
            tx_full_q   <= tx_full_d;
            rx_unread_q <= rx_unread_d;
            overrun_q   <= overrun_d;
            miso_q      <= miso_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            load_pend_q <= load_pend_d;
        end
    end

    assign dat_o   = dat_q;
    assign ack_o   = (state_q == BUS_DONE);
    assign miso    = miso_q;
    assign miso_oe = ss_act;

`ifdef SPI_SLAVE_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = (conf_q[CONF_RXIE] & rx_unread_q)
                 | (conf_q[CONF_TXIE] & ~tx_full_q & ss_act)
                 | overrun_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) irq_q <= 1'b0;
        else         irq_q <= irq_d;
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    logic unused_bus;
    assign unused_bus = ^{sel_i[3], sel_i[1], dat_i[31:24], dat_i[15:8]};

endmodule
